// File: rtl/addsub_pipe.sv
// Multi-lane signed add/subtract with per-transaction wrap or saturate, followed by
// an elastic valid/ready register pipeline of PIPE_STAGES entries.
module addsub_pipe #(
  parameter int DATA_WIDTH  = 32,
  parameter int LANES       = 1,
  parameter int PIPE_STAGES = 2
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        dataAvailible,
  output logic                        in_ready,
  input  logic [1:0]                  in_op,
  input  logic [LANES*DATA_WIDTH-1:0] addend1,
  input  logic [LANES*DATA_WIDTH-1:0] addend2,
  output logic [LANES*DATA_WIDTH-1:0] sum,
  output logic [LANES-1:0]            overflow,
  output logic                        complete,
  input  logic                        out_rd_en
);

  localparam int LW   = LANES * DATA_WIDTH;
  localparam int LAST = PIPE_STAGES - 1;

  logic [PIPE_STAGES-1:0] r_valid;
  logic [LW-1:0]          r_sum [PIPE_STAGES];
  logic [LANES-1:0]       r_ovf [PIPE_STAGES];

  logic [PIPE_STAGES-1:0] w_room;
  logic [PIPE_STAGES-1:0] w_src_valid;
  logic [LW-1:0]          w_src_sum [PIPE_STAGES];
  logic [LANES-1:0]       w_src_ovf [PIPE_STAGES];
  logic [LW-1:0]          w_calc_sum;
  logic [LANES-1:0]       w_calc_ovf;
  logic                   w_chain;
  logic                   w_accept;

  // Per-lane arithmetic on a DATA_WIDTH+1 sign-extended result; the top two bits
  // disagreeing means the true result left the signed range.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    logic [DATA_WIDTH:0]   w_a;
    logic [DATA_WIDTH:0]   w_b;
    logic [DATA_WIDTH:0]   w_r;
    logic                  w_ovf;
    logic [DATA_WIDTH-1:0] w_res;

    always_comb begin
      w_a   = {addend1[l*DATA_WIDTH + DATA_WIDTH-1], addend1[l*DATA_WIDTH +: DATA_WIDTH]};
      w_b   = {addend2[l*DATA_WIDTH + DATA_WIDTH-1], addend2[l*DATA_WIDTH +: DATA_WIDTH]};
      w_r   = in_op[0] ? (w_a - w_b) : (w_a + w_b);
      w_ovf = w_r[DATA_WIDTH] ^ w_r[DATA_WIDTH-1];
      w_res = w_r[DATA_WIDTH-1:0];
      if (in_op[1] && w_ovf)
        w_res = w_r[DATA_WIDTH] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                : {1'b0, {(DATA_WIDTH-1){1'b1}}};
    end

    assign w_calc_sum[l*DATA_WIDTH +: DATA_WIDTH] = w_res;
    assign w_calc_ovf[l]                          = w_ovf;
  end

  // A stage has room if it, or any stage after it, is empty, or the consumer is reading.
  always_comb begin
    w_room  = '0;
    w_chain = out_rd_en;
    for (int s = LAST; s >= 0; s--) begin
      w_chain   = w_chain || !r_valid[s];
      w_room[s] = w_chain;
    end
  end

  assign in_ready = !reset && w_room[0];
  assign w_accept = dataAvailible && in_ready;

  for (genvar s = 0; s < PIPE_STAGES; s++) begin : g_src
    if (s == 0) begin : g_head
      assign w_src_valid[s] = w_accept;
      assign w_src_sum[s]   = w_calc_sum;
      assign w_src_ovf[s]   = w_calc_ovf;
    end else begin : g_body
      assign w_src_valid[s] = r_valid[s-1];
      assign w_src_sum[s]   = r_sum[s-1];
      assign w_src_ovf[s]   = r_ovf[s-1];
    end
  end

  // Data only loads with a valid source so the output holds while stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_valid <= '0;
      for (int s = 0; s < PIPE_STAGES; s++) begin
        r_sum[s] <= '0;
        r_ovf[s] <= '0;
      end
    end else begin
      for (int s = 0; s < PIPE_STAGES; s++) begin
        if (w_room[s]) begin
          r_valid[s] <= w_src_valid[s];
          if (w_src_valid[s]) begin
            r_sum[s] <= w_src_sum[s];
            r_ovf[s] <= w_src_ovf[s];
          end
        end
      end
    end
  end

  assign sum      = r_sum[LAST];
  assign overflow = r_ovf[LAST];
  assign complete = r_valid[LAST];

endmodule

// File: tb/tb_addsub_pipe.sv
// Scoreboard bench for addsub_pipe: accepted inputs push integer-model results,
// an independent monitor pops and compares every output transfer.
module tb_addsub_pipe;
  localparam int DW   = 8;
  localparam int LN   = 2;
  localparam int PS   = 2;
  localparam int LW   = DW * LN;
  localparam int MAXV = (1 << (DW - 1)) - 1;
  localparam int MINV = -(1 << (DW - 1));

  typedef struct packed {
    logic [LW-1:0] sum;
    logic [LN-1:0] ovf;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          dataAvailible = 1'b0;
  logic          in_ready;
  logic [1:0]    in_op = 2'b00;
  logic [LW-1:0] addend1 = '0;
  logic [LW-1:0] addend2 = '0;
  logic [LW-1:0] sum;
  logic [LN-1:0] overflow;
  logic          complete;
  logic          out_rd_en = 1'b0;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   n_out = 0;

  addsub_pipe #(.DATA_WIDTH(DW), .LANES(LN), .PIPE_STAGES(PS)) dut (
    .clock(clock), .reset(reset), .dataAvailible(dataAvailible), .in_ready(in_ready),
    .in_op(in_op), .addend1(addend1), .addend2(addend2), .sum(sum),
    .overflow(overflow), .complete(complete), .out_rd_en(out_rd_en)
  );

  always #5 clock = ~clock;

  function automatic exp_t model(input logic [1:0] op, input logic [LW-1:0] a,
                                 input logic [LW-1:0] b);
    exp_t e;
    int   sa, sb, r;
    bit   ov;
    e = '0;
    for (int l = 0; l < LN; l++) begin
      sa = int'($signed(a[l*DW +: DW]));
      sb = int'($signed(b[l*DW +: DW]));
      r  = op[0] ? sa - sb : sa + sb;
      ov = (r > MAXV) || (r < MINV);
      if (op[1] && ov) r = (r > MAXV) ? MAXV : MINV;
      e.sum[l*DW +: DW] = DW'(r);
      e.ovf[l] = ov;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  // Input side of the scoreboard: every accepted transaction pushes its expected result.
  always @(negedge clock) begin
    if (reset) q.delete();
    else if (dataAvailible && in_ready) q.push_back(model(in_op, addend1, addend2));
  end

  // Output side: every output transfer must match the oldest pending expectation.
  always @(negedge clock) begin
    if (!reset && complete && out_rd_en) begin
      n_out++;
      if (q.size() == 0) begin
        chk("unexpected_output", 64'(sum), 64'hDEAD);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("sb_sum", 64'(sum), 64'(e.sum));
        chk("sb_ovf", 64'(overflow), 64'(e.ovf));
      end
    end
  end

  task automatic issue(input logic [1:0] op, input logic [LW-1:0] a, input logic [LW-1:0] b);
    bit done;
    done = 0;
    in_op = op; addend1 = a; addend2 = b; dataAvailible = 1'b1;
    for (int i = 0; i < 50 && !done; i++) begin
      @(negedge clock);
      if (in_ready) done = 1;
      @(posedge clock); #1;
    end
    dataAvailible = 1'b0;
    if (!done) timeout("issue");
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 50 && q.size() != 0; i++) begin
      @(posedge clock); #1;
    end
    chk(name, 64'(q.size()), 64'd0);
  endtask

  function automatic logic [DW-1:0] pick();
    logic [DW-1:0] v;
    case ($urandom_range(0, 7))
      0: v = 8'h7F;
      1: v = 8'h80;
      2: v = 8'hFF;
      3: v = 8'h01;
      4: v = 8'h00;
      default: v = DW'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    int idx, acc_stall, n0;
    logic [LW-1:0] held_sum;
    logic [LN-1:0] held_ovf;
    bit prev_hold;

    // Reset held with a valid offer: nothing may be accepted or shown.
    dataAvailible = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); @(negedge clock);
      chk("rst_in_ready", 64'(in_ready), 64'd0);
      chk("rst_complete", 64'(complete), 64'd0);
      chk("rst_sum", 64'(sum), 64'd0);
      chk("rst_ovf", 64'(overflow), 64'd0);
    end
    @(posedge clock); #1;
    reset = 1'b0; dataAvailible = 1'b0; out_rd_en = 1'b1;
    @(negedge clock);
    chk("post_rst_in_ready", 64'(in_ready), 64'd1);
    chk("post_rst_complete", 64'(complete), 64'd0);
    @(posedge clock); #1;

    // Wrap add, including the latency boundary.
    issue(2'b00, {8'h10, 8'h7F}, {8'h20, 8'h01});
    @(negedge clock);
    chk("wrap_latency", 64'(complete), 64'd0);
    @(posedge clock); @(negedge clock);
    chk("wrap_complete", 64'(complete), 64'd1);
    chk("wrap_sum", 64'(sum), 64'h3080);
    chk("wrap_ovf", 64'(overflow), 64'b01);
    @(posedge clock); #1;

    issue(2'b10, {8'h80, 8'h7F}, {8'hFF, 8'h01});
    @(posedge clock); @(negedge clock);
    chk("satA_sum", 64'(sum), 64'h807F);
    chk("satA_ovf", 64'(overflow), 64'b11);
    @(posedge clock); #1;

    issue(2'b11, {8'h05, 8'h80}, {8'h03, 8'h01});
    @(posedge clock); @(negedge clock);
    chk("satB_sum", 64'(sum), 64'h0280);
    chk("satB_ovf", 64'(overflow), 64'b01);
    @(posedge clock); #1;
    drain("directed_drain");

    // Backpressure: only PS transactions fit while the consumer stalls.
    idx = 0; acc_stall = 0; n0 = n_out; held_sum = '0; held_ovf = '0;
    for (int c = 0; c < 60 && idx < 5; c++) begin
      out_rd_en = (c >= 6);
      dataAvailible = 1'b1;
      in_op = 2'b00;
      addend1 = {8'h00, 8'(idx + 1)};
      addend2 = '0;
      @(negedge clock);
      if (c >= 2 && c < 6) chk("bp_in_ready", 64'(in_ready), 64'd0);
      if (c == 2) begin held_sum = sum; held_ovf = overflow; end
      if (c == 5) begin
        chk("bp_hold_sum", 64'(sum), 64'(held_sum));
        chk("bp_hold_ovf", 64'(overflow), 64'(held_ovf));
        chk("bp_hold_complete", 64'(complete), 64'd1);
        chk("bp_first_result", 64'(sum), 64'h0001);
      end
      if (in_ready) begin
        idx++;
        if (c < 6) acc_stall++;
      end
      @(posedge clock); #1;
    end
    dataAvailible = 1'b0;
    out_rd_en = 1'b1;
    chk("bp_accepted_stalled", 64'(acc_stall), 64'(PS));
    chk("bp_all_offered", 64'(idx), 64'd5);
    drain("bp_drain");
    chk("bp_out_count", 64'(n_out - n0), 64'd5);

    // Streaming at full throughput.
    n0 = n_out;
    for (int c = 0; c < 20; c++) begin
      dataAvailible = 1'b1;
      out_rd_en = 1'b1;
      in_op = 2'(c);
      addend1 = {8'(2 * c + 1), 8'(c * 9)};
      addend2 = {8'(c), 8'(100 + c * 5)};
      @(negedge clock);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      if (c >= 2) chk("stream_complete", 64'(complete), 64'd1);
      @(posedge clock); #1;
    end
    dataAvailible = 1'b0;
    drain("stream_drain");
    chk("stream_out_count", 64'(n_out - n0), 64'd20);

    // Random traffic with random backpressure; outputs must hold while stalled.
    prev_hold = 0; held_sum = '0; held_ovf = '0;
    for (int c = 0; c < 400; c++) begin
      dataAvailible = ($urandom_range(0, 3) != 0);
      out_rd_en = ($urandom_range(0, 2) != 0);
      in_op = 2'($urandom);
      addend1 = {pick(), pick()};
      addend2 = {pick(), pick()};
      @(negedge clock);
      if (prev_hold) begin
        chk("rand_hold_complete", 64'(complete), 64'd1);
        chk("rand_hold_sum", 64'(sum), 64'(held_sum));
        chk("rand_hold_ovf", 64'(overflow), 64'(held_ovf));
      end
      prev_hold = complete && !out_rd_en;
      held_sum = sum; held_ovf = overflow;
      @(posedge clock); #1;
    end
    dataAvailible = 1'b0;
    out_rd_en = 1'b1;
    drain("rand_drain");

    // Reset with a full pipeline: in-flight results must vanish.
    out_rd_en = 1'b0;
    issue(2'b00, {8'h11, 8'h22}, {8'h01, 8'h02});
    issue(2'b01, {8'h33, 8'h44}, {8'h03, 8'h04});
    @(negedge clock);
    chk("mid_full_complete", 64'(complete), 64'd1);
    chk("mid_full_in_ready", 64'(in_ready), 64'd0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    out_rd_en = 1'b1;
    @(negedge clock);
    chk("mid_rst_complete", 64'(complete), 64'd0);
    chk("mid_rst_sum", 64'(sum), 64'd0);
    chk("mid_rst_ovf", 64'(overflow), 64'd0);
    n0 = n_out;
    for (int i = 0; i < 3; i++) begin
      @(posedge clock); #1;
    end
    chk("mid_rst_no_emit", 64'(n_out - n0), 64'd0);
    issue(2'b00, 16'h0001, 16'h0001);
    @(posedge clock); @(negedge clock);
    chk("mid_new_complete", 64'(complete), 64'd1);
    chk("mid_new_sum", 64'(sum), 64'h0002);
    @(posedge clock); #1;
    drain("final_drain");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
